// File: rtl/card_dealer_pkg.sv
// rtl/card_dealer_pkg.sv - shared constants, state type and LFSR step for the card dealer
package card_dealer_pkg;

  localparam int NUM_SLOTS = 9;
  localparam int DECK_SIZE = 52;

  localparam int SLOT_PLAYER0 = 0;
  localparam int SLOT_PLAYER1 = 1;
  localparam int SLOT_COMM0   = 2;
  localparam int SLOT_COMM4   = 6;
  localparam int SLOT_OPP0    = 7;
  localparam int SLOT_OPP1    = 8;
  localparam int SLOT_LAST    = NUM_SLOTS - 1;

  // Taps for x^16+x^14+x^13+x^11+1 on a left-shifting register (bits 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_DRAW     = 3'd2,
    ST_FALLBACK = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/card_dealer_decode.sv
// rtl/card_dealer_decode.sv - card code 0..51 to number 1..13 and suit 0..3
module card_decode (
  input  logic [5:0] code_i,
  output logic [3:0] num_o,
  output logic [1:0] suit_o
);

  always_comb begin
    if (code_i >= 6'd39) begin
      suit_o = 2'd3;
      num_o  = 4'(code_i - 6'd38);
    end else if (code_i >= 6'd26) begin
      suit_o = 2'd2;
      num_o  = 4'(code_i - 6'd25);
    end else if (code_i >= 6'd13) begin
      suit_o = 2'd1;
      num_o  = 4'(code_i - 6'd12);
    end else begin
      suit_o = 2'd0;
      num_o  = 4'(code_i + 6'd1);
    end
  end

endmodule

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - deals nine distinct cards from a free-running LFSR with a bounded fallback scan
module card_dealer
  import card_dealer_pkg::*;
#(
  parameter int          MAX_TRIES = 63,
  parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        deal_start,
  output logic        busy,
  output logic        done,
  output logic        activate,
  output logic [35:0] card_num,
  output logic [17:0] card_suit
);

  localparam int TW = $clog2(MAX_TRIES + 1);

  state_e                 state_q, state_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [DECK_SIZE-1:0]   used_q, used_d;
  logic [3:0]             slot_q, slot_d;
  logic [TW-1:0]          try_q, try_d;
  logic [35:0]            num_q, num_d;
  logic [17:0]            suit_q, suit_d;
  logic                   act_q, act_d;

  logic [5:0] cand, fb_code, wr_code;
  logic [3:0] draw_num, fb_num, wr_num;
  logic [1:0] draw_suit, fb_suit, wr_suit;
  logic       wr_en, start;

  assign cand = lfsr_q[5:0];

  card_decode u_dec_draw (.code_i(cand),    .num_o(draw_num), .suit_o(draw_suit));
  card_decode u_dec_fb   (.code_i(fb_code), .num_o(fb_num),   .suit_o(fb_suit));

  // Lowest free code; at most eight are ever used, so one always exists
  always_comb begin
    fb_code = 6'd0;
    for (int i = DECK_SIZE - 1; i >= 0; i--) begin
      if (!used_q[i]) fb_code = 6'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_next(lfsr_q);
    used_d  = used_q;
    slot_d  = slot_q;
    try_d   = try_q;
    num_d   = num_q;
    suit_d  = suit_q;
    act_d   = 1'b0;
    wr_en   = 1'b0;
    start   = 1'b0;
    wr_code = cand;
    wr_num  = draw_num;
    wr_suit = draw_suit;

    case (state_q)
      ST_IDLE: begin
        if (seed_load) lfsr_d = (seed == 16'd0) ? LFSR_INIT : seed;
        start = deal_start;
      end
      ST_DONE:  start = deal_start;
      ST_CLEAR: state_d = ST_DRAW;
      ST_DRAW: begin
        if (cand < 6'(DECK_SIZE) && !used_q[cand]) begin
          wr_en = 1'b1;
        end else begin
          try_d = try_q + 1'b1;
          if (try_q == TW'(MAX_TRIES - 1)) state_d = ST_FALLBACK;
        end
      end
      ST_FALLBACK: begin
        wr_en   = 1'b1;
        wr_code = fb_code;
        wr_num  = fb_num;
        wr_suit = fb_suit;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_en) begin
      used_d[wr_code]               = 1'b1;
      num_d[4*int'(slot_q) +: 4]    = wr_num;
      suit_d[2*int'(slot_q) +: 2]   = wr_suit;
      slot_d                        = slot_q + 4'd1;
      try_d                         = '0;
      if (slot_q == 4'(SLOT_LAST)) begin
        state_d = ST_DONE;
        act_d   = 1'b1;
      end else begin
        state_d = ST_DRAW;
      end
    end

    if (start) begin
      state_d = ST_CLEAR;
      used_d  = '0;
      slot_d  = '0;
      try_d   = '0;
      num_d   = '0;
      suit_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_INIT;
      used_q  <= '0;
      slot_q  <= '0;
      try_q   <= '0;
      num_q   <= '0;
      suit_q  <= '0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      used_q  <= used_d;
      slot_q  <= slot_d;
      try_q   <= try_d;
      num_q   <= num_d;
      suit_q  <= suit_d;
      act_q   <= act_d;
    end
  end

  assign busy      = (state_q == ST_CLEAR) || (state_q == ST_DRAW) || (state_q == ST_FALLBACK);
  assign done      = (state_q == ST_DONE);
  assign activate  = act_q;
  assign card_num  = num_q;
  assign card_suit = suit_q;

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - directed and seeded-random deals against a hand-level reference model
module tb_card_dealer;

  localparam logic [15:0] INIT = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'd0;
  logic        deal_start = 1'b0;
  logic [1:0]  busy, done, activate;
  logic [35:0] num [2];
  logic [17:0] suit [2];

  int checks = 0;
  int errors = 0;

  logic [15:0] lfsr_m;
  int exp_code [2][9];
  int exp_cyc  [2][9];
  int exp_tot  [2];

  card_dealer #(.MAX_TRIES(63), .LFSR_INIT(INIT)) dut0 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .deal_start(deal_start),
    .busy(busy[0]), .done(done[0]), .activate(activate[0]), .card_num(num[0]), .card_suit(suit[0]));

  // Second instance falls back after a single reject, so the fallback path is exercised constantly
  card_dealer #(.MAX_TRIES(1), .LFSR_INIT(INIT)) dut1 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed), .deal_start(deal_start),
    .busy(busy[1]), .done(done[1]), .activate(activate[1]), .card_num(num[1]), .card_suit(suit[1]));

  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Stimulus only raises seed_load while the dealers are idle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         lfsr_m <= INIT;
    else if (seed_load) lfsr_m <= (seed == 16'd0) ? INIT : seed;
    else                lfsr_m <= step(lfsr_m);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plays out one hand: one candidate per cycle, fallback to lowest free card after mt straight rejects
  task automatic predict(input int d, input logic [15:0] l0, input int mt);
    bit used [52];
    int tries, slot, cyc, c;
    bit fb;
    logic [15:0] l;
    for (int j = 0; j < 52; j++) used[j] = 1'b0;
    l = l0; tries = 0; slot = 0; cyc = 0; fb = 1'b0;
    while (slot < 9) begin
      cyc++;
      c = -1;
      if (fb) begin
        for (int j = 0; j < 52; j++) if (!used[j]) begin c = j; break; end
        fb = 1'b0;
      end else if (int'(l[5:0]) < 52 && !used[int'(l[5:0])]) begin
        c = int'(l[5:0]);
      end else begin
        tries++;
        if (tries == mt) fb = 1'b1;
      end
      if (c >= 0) begin
        exp_code[d][slot] = c;
        exp_cyc[d][slot]  = cyc;
        used[c] = 1'b1;
        slot++;
        tries = 0;
      end
      l = step(l);
    end
    exp_tot[d] = cyc;
  endtask

  function automatic logic [35:0] exp_num(input int d);
    logic [35:0] v = '0;
    for (int k = 0; k < 9; k++) v[4*k +: 4] = 4'(exp_code[d][k] % 13 + 1);
    return v;
  endfunction

  function automatic logic [17:0] exp_suit(input int d);
    logic [17:0] v = '0;
    for (int k = 0; k < 9; k++) v[2*k +: 2] = 2'(exp_code[d][k] / 13);
    return v;
  endfunction

  function automatic bit hand_ok(input logic [35:0] n, input logic [17:0] s);
    bit seen [52];
    int c, nv;
    for (int j = 0; j < 52; j++) seen[j] = 1'b0;
    for (int k = 0; k < 9; k++) begin
      nv = int'(n[4*k +: 4]);
      if (nv < 1 || nv > 13) return 1'b0;
      c = int'(s[2*k +: 2]) * 13 + nv - 1;
      if (seen[c]) return 1'b0;
      seen[c] = 1'b1;
    end
    return 1'b1;
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    seed_load = 1'b0; deal_start = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_deal(input bit ld, input logic [15:0] sd, input bit pulse, input string tag);
    logic [15:0] l1;
    int win, mint;
    int done_k [2];
    int acts [2];
    @(negedge clk);
    l1 = ld ? ((sd == 16'd0) ? INIT : sd) : step(lfsr_m);
    predict(0, step(l1), 63);
    predict(1, step(l1), 1);
    win  = ((exp_tot[0] > exp_tot[1]) ? exp_tot[0] : exp_tot[1]) + 6;
    mint = (exp_tot[0] < exp_tot[1]) ? exp_tot[0] : exp_tot[1];
    seed_load = ld; seed = sd; deal_start = 1'b1;
    done_k[0] = -1; done_k[1] = -1; acts[0] = 0; acts[1] = 0;
    for (int k = 1; k <= win; k++) begin
      @(negedge clk);
      seed_load  = 1'b0;
      deal_start = pulse && (k % 5 == 0) && (k < mint);
      if (k == 1) begin
        check({tag, " clear busy"}, 64'(busy[0]), 64'd1);
        check({tag, " clear done"}, 64'(done[0]), 64'd0);
        check({tag, " clear num"},  64'(num[0]),  64'd0);
      end
      for (int d = 0; d < 2; d++) begin
        if (done[d] && done_k[d] < 0) done_k[d] = k;
        if (activate[d]) acts[d]++;
      end
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s dut%0d done time", tag, d), 64'(done_k[d]), 64'(exp_tot[d] + 2));
      check($sformatf("%s dut%0d activates", tag, d), 64'(acts[d]), 64'd1);
      check($sformatf("%s dut%0d card_num", tag, d), 64'(num[d]), 64'(exp_num(d)));
      check($sformatf("%s dut%0d card_suit", tag, d), 64'(suit[d]), 64'(exp_suit(d)));
      check($sformatf("%s dut%0d done/busy", tag, d), {62'd0, done[d], busy[d]}, 64'd2);
      check($sformatf("%s dut%0d distinct", tag, d), 64'(hand_ok(num[d], suit[d])), 64'd1);
    end
    check({tag, " within 577"}, 64'(done_k[0] - 1 <= 577), 64'd1);
  endtask

  task automatic reset_mid_deal();
    logic [15:0] l1;
    int target, viol;
    @(negedge clk);
    l1 = step(lfsr_m);
    predict(0, step(l1), 63);
    predict(1, step(l1), 1);
    deal_start = 1'b1;
    target = exp_cyc[0][3] + 2;
    for (int k = 1; k <= target; k++) begin
      @(negedge clk);
      deal_start = 1'b0;
    end
    check("mid slot3 num", 64'(num[0][15:12]), 64'(exp_code[0][3] % 13 + 1));
    check("mid busy", 64'(busy[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("mid rst dut%0d flags", d), {61'd0, busy[d], done[d], activate[d]}, 64'd0);
      check($sformatf("mid rst dut%0d num", d), 64'(num[d]), 64'd0);
      check($sformatf("mid rst dut%0d suit", d), 64'(suit[d]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    viol = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (activate != 2'b00 || done != 2'b00 || busy != 2'b00) viol++;
    end
    check("mid no activate after reset", 64'(viol), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset dut%0d busy", d), 64'(busy[d]), 64'd0);
      check($sformatf("reset dut%0d done", d), 64'(done[d]), 64'd0);
      check($sformatf("reset dut%0d activate", d), 64'(activate[d]), 64'd0);
      check($sformatf("reset dut%0d num", d), 64'(num[d]), 64'd0);
      check($sformatf("reset dut%0d suit", d), 64'(suit[d]), 64'd0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_deal(1'b1, 16'h0000, 1'b0, "seed0");
    reset_dut();
    run_deal(1'b1, 16'h1234, 1'b0, "seed1234");
    run_deal(1'b0, 16'h0000, 1'b1, "pulsed");
    run_deal(1'b0, 16'h0000, 1'b0, "redeal");

    for (int i = 0; i < 4; i++) begin
      reset_dut();
      repeat ($urandom_range(0, 7)) @(negedge clk);
      run_deal(1'b1, 16'($urandom), 1'b0, $sformatf("rand%0d", i));
    end

    reset_dut();
    repeat (4) @(negedge clk);
    reset_mid_deal();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 63, consecutive rejected LFSR candidates before fallback scan.
REQ-002 SHALL have parameter LFSR_INIT, default 16'hACE1, LFSR reset value and substitute for an all-zero seed.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 seed_load  input  1  loads seed into LFSR; honoured only in IDLE.
REQ-007 seed  input  16  LFSR seed; zero is replaced by LFSR_INIT.
REQ-008 deal_start  input  1  one-cycle request to deal a fresh hand; ignored unless IDLE or DONE.
REQ-009 busy  output  1  high while in CLEAR/DRAW/FALLBACK.
REQ-010 done  output  1  high in DONE until the next deal_start.
REQ-011 activate  output  1  one-cycle pulse on DONE entry; drives the hand evaluator's activate.
REQ-012 card_num  output  36  9x4-bit numbers, slot k at [4k+3:4k], range 1..13.
REQ-013 card_suit  output  18  9x2-bit suits, slot k at [2k+1:2k].
REQ-014 Slot map SHALL be: 0,1 player cards; 2..6 community cards 1..5; 7,8 opponent cards.

Function
REQ-015 Card code SHALL be 0..51; number = (code mod 13)+1; suit = code div 13; a valid card number SHALL never be 0.
REQ-016 LFSR SHALL be 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, and SHALL advance every cycle in every state (free-running entropy).
REQ-017 States SHALL be IDLE, CLEAR, DRAW, FALLBACK, DONE.
REQ-018 IDLE/DONE + deal_start -> CLEAR: 52-bit used mask, slot index, try counter, card_num, and card_suit cleared to 0; done dropped.
REQ-019 CLEAR -> DRAW after exactly one cycle.
REQ-020 DRAW: candidate = lfsr[5:0]; accepted if < 52 and its used bit is clear; accept writes slot, sets used bit, index+1, try counter cleared.
REQ-021 DRAW reject SHALL increment the try counter; on reaching MAX_TRIES SHALL go to FALLBACK.
REQ-022 FALLBACK SHALL, in one cycle, take the lowest-numbered free code, accept it as in REQ-020, and return to DRAW.
REQ-023 Acceptance into slot 8 SHALL go to DONE; activate SHALL pulse the first DONE cycle only; card outputs SHALL then hold stable.
REQ-024 Per-card latency SHALL be <= MAX_TRIES+1 cycles; full deal SHALL complete within 1+9*(MAX_TRIES+1) cycles of deal_start.
REQ-025 All nine dealt codes SHALL be distinct.
REQ-026 deal_start while busy SHALL be ignored with no state change; deal_start and seed_load in the same IDLE cycle: seed loads, then deal uses the new LFSR.

Reset
REQ-027 rst_n low SHALL force IDLE, LFSR=LFSR_INIT, mask/index/try counter=0, busy=done=activate=0, card_num=card_suit=0, at any time including mid-deal.
REQ-028 No activate pulse SHALL be emitted for a deal aborted by reset.

Structure
REQ-029 Shared package SHALL hold: state enum, NUM_SLOTS=9, DECK_SIZE=52, slot index constants, LFSR tap constant.
REQ-030 One sub-module card_decode (code -> number, suit, combinational) SHALL be instantiated per write path.

Verification
REQ-031 Reset mid-deal after slot 3 is written -> all outputs 0, IDLE, no activate within the next 600 cycles.
REQ-032 seed_load with seed=0 then deal -> identical card_num/card_suit to a deal started from reset with the same cycle offset.
REQ-033 seed=16'h1234, deal -> done within 577 cycles, one activate pulse, nine distinct codes, all numbers 1..13, suits 0..3.
REQ-034 Force mask with 51 used bits (code 37 free), enter DRAW -> FALLBACK within 64 cycles writes number 12, suit 2.
REQ-035 deal_start pulsed every 5 cycles during a deal -> ignored, single activate; a deal_start in DONE clears outputs and restarts.
